// File: rtl/cache_pkg.sv
// Shared FSM encoding, sizing helpers and default geometry for assoc_cache.
// The CACHE_STATS_EN macro (see assoc_cache) does not change anything here.
package cache_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESPOND} state_e;

   function automatic int off_w(input int words);
      return $clog2(words) + 2;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

   localparam int DEF_WAYS   = 2;
   localparam int DEF_SETS   = 4;
   localparam int DEF_WORDS  = 4;
   localparam int DEF_ADDR_W = 32;

   localparam int OFF_W = off_w(DEF_WORDS);
   localparam int IDX_W = idx_w(DEF_SETS);
   localparam int TAG_W = DEF_ADDR_W - OFF_W - IDX_W;

   typedef logic [32*DEF_WORDS-1:0] line_t;

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection: lowest invalid way, else the per-set round-robin
// pointer, which advances on every fill of its set.
module cache_victim_sel
   import cache_pkg::*;
#(
   parameter int WAYS = DEF_WAYS,
   parameter int SETS = DEF_SETS,
   parameter int IW   = idx_w(SETS),
   parameter int WW   = way_w(WAYS)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [IW-1:0]   idx_i,
   input  logic [WAYS-1:0] valid_i,
   input  logic            fill_i,
   output logic [WW-1:0]   victim_o
);

   logic [WW-1:0] ptr_q [SETS];

   always_comb begin
      victim_o = ptr_q[idx_i];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_i[w]) victim_o = WW'(w);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (fill_i) begin
         if (ptr_q[idx_i] == WW'(WAYS - 1)) ptr_q[idx_i] <= '0;
         else ptr_q[idx_i] <= ptr_q[idx_i] + WW'(1);
      end
   end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with its own miss FSM.
// Define CACHE_STATS_EN to get saturating hit/miss counters.
module assoc_cache
   import cache_pkg::*;
#(
   parameter int WAYS   = DEF_WAYS,
   parameter int SETS   = DEF_SETS,
   parameter int WORDS  = DEF_WORDS,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic                req_byte,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [31:0]         req_wdata,
   output logic                resp_valid,
   output logic [31:0]         resp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_write,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [32*WORDS-1:0] mem_wblock,
   input  logic                mem_resp_valid,
   input  logic [32*WORDS-1:0] mem_rblock,
   output logic [31:0]         hit_count,
   output logic [31:0]         miss_count
);

   localparam int OW = off_w(WORDS);
   localparam int IW = idx_w(SETS);
   localparam int TW = ADDR_W - OW - IW;
   localparam int WW = way_w(WAYS);
   localparam int LW = 32 * WORDS;
   localparam int SW = OW - 2;

   state_e            state_q, state_d;
   logic              write_q, write_d, byte_q, byte_d;
   logic [ADDR_W-1:0] addr_q, addr_d, maddr_q, maddr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic              sent_q, sent_d;
   logic [WW-1:0]     way_q, way_d;
   logic [LW-1:0]     wblk_q, wblk_d;

   logic [TW-1:0]     tag_q   [SETS][WAYS];
   logic [LW-1:0]     data_q  [SETS][WAYS];
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];

   logic [IW-1:0]     idx;
   logic [TW-1:0]     tag;
   logic [SW-1:0]     wsel;
   logic [1:0]        lane;
   logic [ADDR_W-1:0] fill_addr;
   logic              hit, wr_en, fill_en;
   logic [WW-1:0]     hway, victim;
   logic [LW-1:0]     line, nline;
   logic [31:0]       word, wword, rword;

   assign idx       = addr_q[OW +: IW];
   assign tag       = addr_q[ADDR_W-1 -: TW];
   assign wsel      = addr_q[2 +: SW];
   assign lane      = addr_q[1:0];
   assign fill_addr = {tag, idx, {OW{1'b0}}};

   always_comb begin
      hit  = 1'b0;
      hway = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
            hit  = 1'b1;
            hway = WW'(w);
         end
      end
   end

   // Read and merged-store views of the hit line.
   always_comb begin
      line  = data_q[idx][hway];
      word  = line[32*int'(wsel) +: 32];
      rword = byte_q ? {24'h0, word[8*int'(lane) +: 8]} : word;
      wword = wdata_q;
      if (byte_q) begin
         wword = word;
         wword[8*int'(lane) +: 8] = wdata_q[7:0];
      end
      nline = line;
      nline[32*int'(wsel) +: 32] = wword;
   end

   cache_victim_sel #(.WAYS(WAYS), .SETS(SETS)) u_vsel (
      .clock    (clock),
      .reset    (reset),
      .idx_i    (idx),
      .valid_i  (valid_q[idx]),
      .fill_i   (fill_en),
      .victim_o (victim)
   );

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      byte_d  = byte_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sent_d  = sent_q;
      way_d   = way_q;
      maddr_d = maddr_q;
      wblk_d  = wblk_q;
      rdata_d = rdata_q;
      wr_en   = 1'b0;
      fill_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               byte_d  = req_byte;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            sent_d = 1'b0;
            if (hit) begin
               wr_en   = write_q;
               rdata_d = write_q ? 32'h0 : rword;
               state_d = RESPOND;
            end else begin
               way_d = victim;
               if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                  maddr_d = {tag_q[idx][victim], idx, {OW{1'b0}}};
                  wblk_d  = data_q[idx][victim];
                  state_d = WB;
               end else begin
                  maddr_d = fill_addr;
                  state_d = FILL;
               end
            end
         end
         WB: begin
            if (!sent_q) begin
               sent_d = mem_req_ready;
            end else if (mem_resp_valid) begin
               sent_d  = 1'b0;
               maddr_d = fill_addr;
               state_d = FILL;
            end
         end
         FILL: begin
            if (!sent_q) begin
               sent_d = mem_req_ready;
            end else if (mem_resp_valid) begin
               fill_en = 1'b1;
               state_d = LOOKUP;
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         write_q <= 1'b0;
         byte_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sent_q  <= 1'b0;
         way_q   <= '0;
         maddr_q <= '0;
         wblk_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sent_q  <= sent_d;
         way_q   <= way_d;
         maddr_q <= maddr_d;
         wblk_q  <= wblk_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]  <= '0;
               data_q[s][w] <= '0;
            end
         end
      end else if (wr_en) begin
         data_q[idx][hway]  <= nline;
         dirty_q[idx][hway] <= 1'b1;
      end else if (fill_en) begin
         data_q[idx][way_q]  <= mem_rblock;
         tag_q[idx][way_q]   <= tag;
         valid_q[idx][way_q] <= 1'b1;
         dirty_q[idx][way_q] <= 1'b0;
      end
   end

   assign req_ready     = (state_q == IDLE) && !reset;
   assign resp_valid    = (state_q == RESPOND);
   assign resp_rdata    = rdata_q;
   assign mem_req_valid = ((state_q == WB) || (state_q == FILL)) && !sent_q;
   assign mem_req_write = (state_q == WB);
   assign mem_addr      = maddr_q;
   assign mem_wblock    = wblk_q;

`ifdef CACHE_STATS_EN
   logic        first_q;
   logic [31:0] hits_q, miss_q;

   // Only the first LOOKUP of a request is counted, never the replay.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         first_q <= 1'b0;
         hits_q  <= '0;
         miss_q  <= '0;
      end else begin
         if (state_q == IDLE && req_valid) first_q <= 1'b1;
         else if (state_q == LOOKUP) first_q <= 1'b0;
         if (state_q == LOOKUP && first_q) begin
            if (hit && hits_q != '1) hits_q <= hits_q + 32'd1;
            if (!hit && miss_q != '1) miss_q <= miss_q + 32'd1;
         end
      end
   end

   assign hit_count  = hits_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Randomized bench for assoc_cache against a behavioural cache/memory model,
// with directed cases for fill, hit latency, byte access, eviction and reset.
module tb_assoc_cache;
   import cache_pkg::*;

   localparam int WAYS  = DEF_WAYS;
   localparam int SETS  = DEF_SETS;
   localparam int WORDS = DEF_WORDS;
   localparam int AW    = DEF_ADDR_W;
   localparam int LB    = 4 * WORDS;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      line_t       blk;
   } mop_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_ready, req_write = 1'b0, req_byte = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          mem_req_valid, mem_req_ready = 1'b0, mem_req_write;
   logic [AW-1:0] mem_addr;
   line_t         mem_wblock;
   logic          mem_resp_valid = 1'b0;
   line_t         mem_rblock = '0;
   logic [31:0]   hit_count, miss_count;

   always #5 clock = ~clock;

   assoc_cache #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_byte(req_byte),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_addr(mem_addr),
      .mem_wblock(mem_wblock), .mem_resp_valid(mem_resp_valid),
      .mem_rblock(mem_rblock),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   int n_chk = 0;
   int n_pass = 0;

   mop_t             expq[$];
   logic [31:0]      mem [int unsigned];
   logic [TAG_W-1:0] mtag   [SETS][WAYS];
   line_t            mdata  [SETS][WAYS];
   bit               mvalid [SETS][WAYS];
   bit               mdirty [SETS][WAYS];
   int               mptr   [SETS];
   int               mhits, mmiss;

   logic [31:0] last_rdata;
   int          last_lat;
   logic [31:0] wb_addr;
   line_t       wb_blk;
   int          nstall;

   function automatic void chk(input string nm, input logic [127:0] act,
                               input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endfunction

   function automatic logic [31:0] memrd(input int unsigned k);
      return mem.exists(k) ? mem[k] : k * 32'h9E37_79B9;
   endfunction

   function automatic line_t memline(input logic [31:0] la);
      line_t b;
      for (int i = 0; i < WORDS; i++) b[32*i +: 32] = memrd((la >> 2) + i);
      return b;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         mptr[s] = 0;
         for (int w = 0; w < WAYS; w++) begin
            mvalid[s][w] = 0;
            mdirty[s][w] = 0;
         end
      end
      mhits = 0;
      mmiss = 0;
      expq.delete();
   endfunction

   // Whole-request model: decides hit/miss, queues the memory ops the
   // cache must issue, and returns the load data.
   function automatic void model_access(input bit wr, input bit bt,
         input logic [31:0] a, input logic [31:0] wd,
         output bit hit, output logic [31:0] rd);
      int idx, way, v, wi, ln;
      logic [TAG_W-1:0] tg;
      logic [31:0] la, wv;
      line_t l;
      idx = int'((a >> OFF_W) % SETS);
      tg  = TAG_W'(a >> (OFF_W + IDX_W));
      wi  = int'((a >> 2) % WORDS);
      ln  = int'(a % 4);
      hit = 0;
      way = 0;
      for (int w = 0; w < WAYS; w++)
         if (mvalid[idx][w] && mtag[idx][w] == tg) begin hit = 1; way = w; end
      if (hit) mhits++;
      else begin
         mmiss++;
         v = -1;
         for (int w = 0; w < WAYS; w++) if (!mvalid[idx][w] && v < 0) v = w;
         if (v < 0) v = mptr[idx];
         if (mvalid[idx][v] && mdirty[idx][v])
            expq.push_back('{1'b1, (32'(mtag[idx][v]) << (OFF_W + IDX_W)) |
                             (32'(idx) << OFF_W), mdata[idx][v]});
         la = a & ~32'(LB - 1);
         expq.push_back('{1'b0, la, memline(la)});
         mdata[idx][v]  = memline(la);
         mtag[idx][v]   = tg;
         mvalid[idx][v] = 1;
         mdirty[idx][v] = 0;
         mptr[idx] = (mptr[idx] + 1) % WAYS;
         way = v;
      end
      l  = mdata[idx][way];
      wv = l[32*wi +: 32];
      if (wr) begin
         if (bt) wv[8*ln +: 8] = wd[7:0];
         else wv = wd;
         l[32*wi +: 32] = wv;
         mdata[idx][way] = l;
         mdirty[idx][way] = 1;
         rd = 32'h0;
      end else begin
         rd = bt ? (wv >> (8 * ln)) & 32'hFF : wv;
      end
   endfunction

   task automatic chk_counts();
`ifdef CACHE_STATS_EN
      chk("hit_count", hit_count, mhits);
      chk("miss_count", miss_count, mmiss);
`else
      chk("hit_count", hit_count, 0);
      chk("miss_count", miss_count, 0);
`endif
   endtask

   task automatic chk_reset_vals(input string tagn);
      chk({tagn, " req_ready"}, req_ready, 0);
      chk({tagn, " resp_valid"}, resp_valid, 0);
      chk({tagn, " resp_rdata"}, resp_rdata, 0);
      chk({tagn, " mem_req_valid"}, mem_req_valid, 0);
      chk({tagn, " mem_req_write"}, mem_req_write, 0);
      chk({tagn, " mem_addr"}, mem_addr, 0);
      chk({tagn, " mem_wblock"}, mem_wblock, 0);
      chk({tagn, " hit_count"}, hit_count, 0);
      chk({tagn, " miss_count"}, miss_count, 0);
   endtask

   // Issues one request, plays the memory side and checks every cycle.
   task automatic do_req(input bit wr, input bit bt, input logic [31:0] a,
         input logic [31:0] wd, input int stall, input bit rst_abort);
      bit mh, done, hs, waiting;
      logic [31:0] mrd;
      int cyc, wcnt, st;
      mop_t cur;
      model_access(wr, bt, a, wd, mh, mrd);
      st = stall;
      nstall = 0;
      cyc = 0;
      do begin @(negedge clock); cyc++; end while (!req_ready && cyc < 50);
      chk("req_ready idle", req_ready, 1);
      req_valid = 1; req_write = wr; req_byte = bt; req_addr = a; req_wdata = wd;
      done = 0; hs = 0; waiting = 0; cyc = 0; wcnt = 0;
      cur = '{1'b0, 32'h0, '0};
      while (!done) begin
         @(negedge clock);
         cyc++;
         req_valid = 0;
         req_write = 1'($urandom); req_byte = 1'($urandom);
         req_addr = $urandom; req_wdata = $urandom;
         mem_resp_valid = 0;
         if (cyc > 400) begin
            n_chk++;
            $display("FAIL timeout: no resp_valid after %0d cycles for addr %0h", cyc, a);
            done = 1;
         end else if (resp_valid) begin
            chk("resp_rdata", resp_rdata, mrd);
            chk("mem ops drained", expq.size(), 0);
            if (mh) chk("hit latency", cyc, 2);
            chk_counts();
            last_rdata = resp_rdata;
            last_lat = cyc;
            done = 1;
         end else begin
            chk("req_ready busy", req_ready, 0);
            if (hs) begin
               mem_req_ready = 0;
               hs = 0;
               chk("mem_req_valid drop", mem_req_valid, 0);
               waiting = 1;
               wcnt = $urandom_range(0, 3);
            end else if (waiting) begin
               if (rst_abort && cur.wr) begin
                  reset = 1;
                  #1;
                  chk_reset_vals("mid-op reset");
                  @(negedge clock);
                  reset = 0;
                  model_reset();
                  done = 1;
               end else if (wcnt == 0) begin
                  mem_resp_valid = 1;
                  mem_rblock = cur.blk;
                  waiting = 0;
                  if (cur.wr)
                     for (int i = 0; i < WORDS; i++)
                        mem[(cur.addr >> 2) + i] = cur.blk[32*i +: 32];
               end else wcnt--;
            end else if (mem_req_valid) begin
               if (expq.size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected mem req: addr %0h write %0b, want none",
                           mem_addr, mem_req_write);
               end else begin
                  chk("mem_req_write", mem_req_write, expq[0].wr);
                  chk("mem_addr", mem_addr, expq[0].addr);
                  if (expq[0].wr) chk("mem_wblock", mem_wblock, expq[0].blk);
                  if (st > 0 && !expq[0].wr) begin
                     st--;
                     nstall++;
                     if ($urandom_range(0, 2) == 0) begin
                        mem_resp_valid = 1;
                        mem_rblock = ~expq[0].blk;
                     end
                  end else if ($urandom_range(0, 3) == 0) begin
                     if ($urandom_range(0, 1) == 0) begin
                        mem_resp_valid = 1;
                        mem_rblock = ~expq[0].blk;
                     end
                  end else begin
                     cur = expq.pop_front();
                     mem_req_ready = 1;
                     hs = 1;
                     if (cur.wr) begin
                        wb_addr = mem_addr;
                        wb_blk = mem_wblock;
                     end
                  end
               end
            end
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit wr, bt;
      logic [31:0] a;
      model_reset();
      mem[32'h10] = 32'hAAAA_AAAA;
      mem[32'h11] = 32'hBBBB_BBBB;
      mem[32'h12] = 32'hCCCC_CCCC;
      mem[32'h13] = 32'hDDDD_DDDD;
      repeat (2) @(negedge clock);
      chk_reset_vals("reset");
      reset = 0;
      @(negedge clock);
      chk("req_ready after reset", req_ready, 1);

      do_req(0, 0, 32'h40, 0, 0, 0);
      chk("t1 rdata", last_rdata, 32'hAAAA_AAAA);
`ifdef CACHE_STATS_EN
      chk("t1 miss_count", miss_count, 1);
`endif
      do_req(0, 0, 32'h40, 0, 0, 0);
      chk("t2 hit latency", last_lat, 2);
`ifdef CACHE_STATS_EN
      chk("t2 hit_count", hit_count, 1);
`endif
      do_req(1, 1, 32'h43, 32'h0000_005A, 0, 0);
      chk("t3 store rdata", last_rdata, 0);
      do_req(0, 1, 32'h43, 0, 0, 0);
      chk("t3 byte load", last_rdata, 32'h0000_005A);
      do_req(0, 0, 32'h40, 0, 0, 0);
      chk("t3 word load", last_rdata, 32'h5AAA_AAAA);

      do_req(0, 0, 32'h140, 0, 0, 0);
      wb_addr = '0;
      wb_blk = '0;
      do_req(0, 0, 32'h240, 0, 0, 0);
      chk("t4 wb addr", wb_addr, 32'h40);
      chk("t4 wb byte3", wb_blk[31:24], 8'h5A);

      do_req(0, 0, 32'h340, 0, 10, 0);
      chk("t5 fill stall cycles", nstall, 10);

      do_req(1, 0, 32'h240, 32'h1234_5678, 0, 0);
      do_req(0, 0, 32'h440, 0, 0, 1);
      do_req(0, 0, 32'h40, 0, 0, 0);
      chk("t6 post-reset miss", last_lat > 2, 1);
      chk("t6 post-reset data", last_rdata, 32'h5AAA_AAAA);

      for (int n = 0; n < 400; n++) begin
         wr = 1'($urandom);
         bt = 1'($urandom);
         a = 32'($urandom_range(0, 23)) * 32'(LB) + 32'($urandom_range(0, WORDS - 1)) * 4;
         if (bt) a = a + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = a | 32'hF000_0000;
         do_req(wr, bt, a, $urandom, ($urandom_range(0, 3) == 0) ? 5 : 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
